lidar_range_encoder_core: RTL and testbench



---
 rtl/lidar_range_encoder_core_if.sv | 61 ++++++
 rtl/lidar_range_encoder_core.sv | 210 +++++++++++++++++++++
 tb/tb_lidar_range_encoder_core.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lidar_range_encoder_core_if.sv
// Symbol-in / byte-out bundle for the LiDAR range encoder.
// RANGE_ENC_STATS_EN adds the statistics counters to the bundle.
interface lidar_range_encoder_core_if;
    logic        sym_valid;
    logic        sym_ready;
    logic [15:0] cum_freq;
    logic [15:0] freq;
    logic [15:0] total_freq;
    logic        flush_req;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  byte_data;
    logic        busy;
    logic        flush_done;
    logic        sym_error;
`ifdef RANGE_ENC_STATS_EN
    logic [31:0] sym_count;
    logic [31:0] byte_count;
    logic [15:0] err_count;
`endif

    modport slave (
`ifdef RANGE_ENC_STATS_EN
        output sym_count,
        output byte_count,
        output err_count,
`endif
        input  sym_valid,
        output sym_ready,
        input  cum_freq,
        input  freq,
        input  total_freq,
        input  flush_req,
        output byte_valid,
        input  byte_ready,
        output byte_data,
        output busy,
        output flush_done,
        output sym_error
    );

    modport master (
`ifdef RANGE_ENC_STATS_EN
        input  sym_count,
        input  byte_count,
        input  err_count,
`endif
        output sym_valid,
        input  sym_ready,
        output cum_freq,
        output freq,
        output total_freq,
        output flush_req,
        input  byte_valid,
        output byte_ready,
        input  byte_data,
        input  busy,
        input  flush_done,
        input  sym_error
    );
endinterface

// File: rtl/lidar_range_encoder_core.sv
// Arithmetic range encoder: 32-bit low/range, serial divider, carry-aware byte output.
// Optional macro RANGE_ENC_STATS_EN adds sym/byte/err statistics counters.
module lidar_range_encoder_core #(
    parameter int PEND_W    = 16,
    parameter int TOP_SHIFT = 24
) (
    input logic                        clk,
    input logic                        reset,
    lidar_range_encoder_core_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE, DIV, UPD, RENORM, SHIFT, EMIT, FLUSH
    } state_t;

    localparam logic [31:0] RANGE_TOP = 32'd1 << TOP_SHIFT;

    state_t              state_q, state_d;
    logic [32:0]         low_q;
    logic [31:0]         range_q;
    logic [7:0]          cache_q;
    logic [PEND_W-1:0]   csize_q;
    logic [PEND_W-1:0]   pend_q;
    logic [15:0]         cum_q, freq_q, tot_q;
    logic [31:0]         quo_q;
    logic [15:0]         rem_q;
    logic [4:0]          div_cnt_q;
    logic [7:0]          byte_q;
    logic                flush_mode_q;
    logic [2:0]          flush_cnt_q;
    logic                flush_done_q;
    logic                sym_error_q;

    logic                sym_bad, accept, reject, start_flush;
    logic [16:0]         rem_sh;
    logic                q_bit;
    logic [15:0]         rem_nx;
    logic [31:0]         prod_c, prod_f;
    logic                carry, do_emit, xfer, last_byte, shift_done;
    logic                flush_end;
    logic [7:0]          top_byte;
    logic [32:0]         low_sh;
    logic [PEND_W-1:0]   csize_inc;

    assign sym_bad = (bus.total_freq == 16'd0) || (bus.freq == 16'd0) ||
                     (({1'b0, bus.cum_freq} + {1'b0, bus.freq}) >
                      {1'b0, bus.total_freq});
    assign accept      = (state_q == IDLE) && bus.sym_valid && !sym_bad;
    assign reject      = (state_q == IDLE) && bus.sym_valid && sym_bad;
    assign start_flush = (state_q == IDLE) && !bus.sym_valid && bus.flush_req;

    // restoring divide step: the dividend is shifted out of quo_q MSB-first
    assign rem_sh = {rem_q, quo_q[31]};
    assign q_bit  = rem_sh >= {1'b0, tot_q};
    assign rem_nx = q_bit ? 16'(rem_sh - {1'b0, tot_q}) : rem_sh[15:0];

    // q*cum < range always, so 32 bits are enough before the 33-bit add
    assign prod_c = quo_q * {16'd0, cum_q};
    assign prod_f = quo_q * {16'd0, freq_q};

    assign carry      = low_q[32];
    assign top_byte   = low_q[31:24];
    assign do_emit    = (top_byte != 8'hFF) || carry;
    assign xfer       = (state_q == EMIT) && bus.byte_ready;
    assign last_byte  = pend_q == '0;
    assign shift_done = ((state_q == SHIFT) && !do_emit) ||
                        (xfer && last_byte);
    assign flush_end  = (state_q == FLUSH) && (flush_cnt_q == 3'd5);
    assign low_sh     = {1'b0, low_q[23:0], 8'h00};
    assign csize_inc  = (csize_q == '1) ? csize_q : csize_q + PEND_W'(1);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept)           state_d = DIV;
                else if (start_flush) state_d = FLUSH;
            end
            DIV:    if (div_cnt_q == 5'd31) state_d = UPD;
            UPD:    state_d = RENORM;
            RENORM: state_d = (range_q < RANGE_TOP) ? SHIFT : IDLE;
            SHIFT: begin
                if (do_emit)           state_d = EMIT;
                else if (flush_mode_q) state_d = FLUSH;
                else                   state_d = RENORM;
            end
            EMIT: begin
                if (xfer && last_byte)
                    state_d = flush_mode_q ? FLUSH : RENORM;
            end
            FLUSH:  state_d = (flush_cnt_q == 3'd5) ? IDLE : SHIFT;
            default: state_d = IDLE;
        endcase
    end

    // coder datapath: divider, interval update, shift_low and flush
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            low_q        <= 33'h0;
            range_q      <= 32'hFFFF_FFFF;
            cache_q      <= 8'h00;
            csize_q      <= PEND_W'(1);
            pend_q       <= '0;
            cum_q        <= 16'h0;
            freq_q       <= 16'h0;
            tot_q        <= 16'h0;
            quo_q        <= 32'h0;
            rem_q        <= 16'h0;
            div_cnt_q    <= 5'd0;
            byte_q       <= 8'h00;
            flush_mode_q <= 1'b0;
            flush_cnt_q  <= 3'd0;
            flush_done_q <= 1'b0;
            sym_error_q  <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            sym_error_q  <= reject;
            if (accept) begin
                cum_q     <= bus.cum_freq;
                freq_q    <= bus.freq;
                tot_q     <= bus.total_freq;
                quo_q     <= range_q;
                rem_q     <= 16'h0;
                div_cnt_q <= 5'd0;
            end
            if (start_flush) begin
                flush_mode_q <= 1'b1;
                flush_cnt_q  <= 3'd0;
            end
            if (state_q == DIV) begin
                quo_q     <= {quo_q[30:0], q_bit};
                rem_q     <= rem_nx;
                div_cnt_q <= div_cnt_q + 5'd1;
            end
            if (state_q == UPD) begin
                low_q   <= low_q + {1'b0, prod_c};
                range_q <= prod_f;
            end
            if ((state_q == SHIFT) && do_emit) begin
                byte_q <= cache_q + {7'd0, carry};
                pend_q <= csize_q - PEND_W'(1);
            end
            if (xfer && !last_byte) begin
                byte_q <= 8'hFF + {7'd0, carry};
                pend_q <= pend_q - PEND_W'(1);
            end
            if (shift_done) begin
                low_q <= low_sh;
                if (do_emit) begin
                    cache_q <= top_byte;
                    csize_q <= PEND_W'(1);
                end else begin
                    csize_q <= csize_inc;
                end
                if (flush_mode_q) flush_cnt_q <= flush_cnt_q + 3'd1;
                else              range_q <= {range_q[23:0], 8'h00};
            end
            if (flush_end) begin
                low_q        <= 33'h0;
                range_q      <= 32'hFFFF_FFFF;
                cache_q      <= 8'h00;
                csize_q      <= PEND_W'(1);
                flush_mode_q <= 1'b0;
                flush_done_q <= 1'b1;
            end
        end
    end

    assign bus.sym_ready  = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.byte_valid = state_q == EMIT;
    assign bus.byte_data  = byte_q;
    assign bus.flush_done = flush_done_q;
    assign bus.sym_error  = sym_error_q;

`ifdef RANGE_ENC_STATS_EN
    logic [31:0] sym_cnt_q;
    logic [31:0] byte_cnt_q;
    logic [15:0] err_cnt_q;

    // statistics, cleared together with the stream on flush completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_cnt_q  <= 32'd0;
            byte_cnt_q <= 32'd0;
            err_cnt_q  <= 16'd0;
        end else if (flush_end) begin
            sym_cnt_q  <= 32'd0;
            byte_cnt_q <= 32'd0;
            err_cnt_q  <= 16'd0;
        end else begin
            if (accept) sym_cnt_q  <= sym_cnt_q + 32'd1;
            if (xfer)   byte_cnt_q <= byte_cnt_q + 32'd1;
            if (reject) err_cnt_q  <= err_cnt_q + 16'd1;
        end
    end

    assign bus.sym_count  = sym_cnt_q;
    assign bus.byte_count = byte_cnt_q;
    assign bus.err_count  = err_cnt_q;
`endif

endmodule

// File: tb/tb_lidar_range_encoder_core.sv
// Directed bench for lidar_range_encoder_core.
// Hand-derived byte streams and low/range values after each symbol.
module tb_lidar_range_encoder_core;

    logic clk = 1'b0;
    logic reset = 1'b1;

    lidar_range_encoder_core_if bus();

    lidar_range_encoder_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    logic [15:0] rc[3] = '{16'h0000, 16'h00F0, 16'h0010};
    logic [15:0] rf[3] = '{16'h0010, 16'h0020, 16'h0000};
    logic [15:0] rt[3] = '{16'h0000, 16'h0100, 16'h0100};

    // collect every transferred byte
    always @(posedge clk) begin
        if (!reset && bus.byte_valid && bus.byte_ready)
            got_q.push_back(bus.byte_data);
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic expect_bytes(input string tag);
        check({tag, "_n"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check(tag, 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic issue(input logic [15:0] c, input logic [15:0] f,
                         input logic [15:0] t);
        bus.cum_freq   = c;
        bus.freq       = f;
        bus.total_freq = t;
        bus.sym_valid  = 1'b1;
        @(negedge clk);
        bus.sym_valid  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(bus.busy), 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.byte_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(bus.byte_valid), 64'd1);
    endtask

    task automatic do_flush(input string tag);
        int n;
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        wait_idle({tag, "_idle"}, n);
        check({tag, "_done"}, 64'(bus.flush_done), 64'd1);
        @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.flush_done), 64'd0);
    endtask

    initial begin
        bus.sym_valid  = 1'b0;
        bus.cum_freq   = 16'h0;
        bus.freq       = 16'h0;
        bus.total_freq = 16'h0;
        bus.flush_req  = 1'b0;
        bus.byte_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check("rst_ready", 64'(bus.sym_ready), 64'd1);
        check("rst_bvalid", 64'(bus.byte_valid), 64'd0);
        check("rst_bdata", 64'(bus.byte_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_fdone", 64'(bus.flush_done), 64'd0);
        check("rst_err", 64'(bus.sym_error), 64'd0);
        check("rst_range", 64'(dut.range_q), 64'hFFFF_FFFF);
        check("rst_low", 64'(dut.low_q), 64'd0);

        do_flush("flush0");
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_bytes("flush0_bytes");
        check("flush0_range", 64'(dut.range_q), 64'hFFFF_FFFF);

        issue(16'h0000, 16'h0080, 16'h0100);
        wait_idle("s1_idle", cyc);
        check("s1_latency", 64'(cyc), 64'd34);
        check("s1_range", 64'(dut.range_q), 64'h7FFF_FF80);
        check("s1_low", 64'(dut.low_q), 64'd0);
        expect_bytes("s1_bytes");
        do_flush("flush1");
        exp_q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_bytes("flush1_bytes");
        check("flush1_range", 64'(dut.range_q), 64'hFFFF_FFFF);

        issue(16'h00FF, 16'h0001, 16'h0100);
        wait_idle("s2_idle", cyc);
        exp_q = '{8'h00};
        expect_bytes("s2_bytes");
        check("s2_low", 64'(dut.low_q), 64'h0_FFFF_0100);
        check("s2_range", 64'(dut.range_q), 64'hFFFF_FF00);
        check("s2_cache", 64'(dut.cache_q), 64'hFE);

        for (int i = 0; i < 3; i++) begin
            issue(rc[i], rf[i], rt[i]);
            check("rej_err", 64'(bus.sym_error), 64'd1);
            check("rej_ready", 64'(bus.sym_ready), 64'd1);
            check("rej_busy", 64'(bus.busy), 64'd0);
            @(negedge clk);
            check("rej_pulse", 64'(bus.sym_error), 64'd0);
            check("rej_bvalid", 64'(bus.byte_valid), 64'd0);
        end
        check("rej_low", 64'(dut.low_q), 64'h0_FFFF_0100);
        check("rej_range", 64'(dut.range_q), 64'hFFFF_FF00);
        expect_bytes("rej_bytes");

        bus.byte_ready = 1'b0;
        issue(16'h00FF, 16'h0001, 16'h0100);
        wait_valid("stall_valid");
        for (int i = 0; i < 10; i++) begin
            check("stall_bvalid", 64'(bus.byte_valid), 64'd1);
            check("stall_bdata", 64'(bus.byte_data), 64'hFF);
            check("stall_ready", 64'(bus.sym_ready), 64'd0);
            @(negedge clk);
        end
        bus.byte_ready = 1'b1;
        wait_idle("s3_idle", cyc);
        check("s3_low", 64'(dut.low_q), 64'h0_FF00_0100);
        check("s3_range", 64'(dut.range_q), 64'hFFFF_FF00);
        exp_q = '{8'hFF};
        expect_bytes("s3_bytes");
        do_flush("flush2");
        exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h00};
        expect_bytes("flush2_bytes");

        issue(16'h00FF, 16'h0001, 16'h0100);
        wait_idle("s4_idle", cyc);
        issue(16'h00FF, 16'h0001, 16'h0100);
        wait_idle("s5_idle", cyc);
        exp_q = '{8'h00, 8'hFF};
        expect_bytes("s45_bytes");
        bus.byte_ready = 1'b0;
        issue(16'h00FF, 16'h0001, 16'h0100);
        wait_valid("s6_valid");
        check("s6_bdata", 64'(bus.byte_data), 64'hFF);
        reset = 1'b1;
        #1;
        check("mid_ready", 64'(bus.sym_ready), 64'd1);
        check("mid_bvalid", 64'(bus.byte_valid), 64'd0);
        check("mid_bdata", 64'(bus.byte_data), 64'd0);
        check("mid_busy", 64'(bus.busy), 64'd0);
        check("mid_fdone", 64'(bus.flush_done), 64'd0);
        check("mid_err", 64'(bus.sym_error), 64'd0);
        check("mid_range", 64'(dut.range_q), 64'hFFFF_FFFF);
        check("mid_low", 64'(dut.low_q), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.byte_ready = 1'b1;
        @(negedge clk);
        expect_bytes("mid_bytes");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
